// File: rtl/pc_seq_pkg.sv
// Shared definitions for the next-PC sequencer: op codes, FSM states and
// the latched request record.
package pc_seq_pkg;

    localparam logic [2:0] OP_SEQ  = 3'd0;
    localparam logic [2:0] OP_BR   = 3'd1;
    localparam logic [2:0] OP_JMP  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;

    // The adder doubles in1, so an in1 of 1 advances the PC by one 2-byte word.
    localparam logic [15:0] PC_INC_IN1 = 16'h0001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        CALL2 = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]  op;
        logic        taken;
        logic [15:0] offset;
        logic [15:0] target;
    } req_t;

    function automatic logic is_taken_br(input logic [2:0] op, input logic taken);
        return (op == OP_BR) && taken;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Request handshake between the core control FSM (master) and the
// next-PC sequencer (slave).
interface pc_sequencer_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic        req_taken;
    logic [15:0] req_offset;
    logic [15:0] req_target;

    modport master (
        output req_valid,
        output req_op,
        output req_taken,
        output req_offset,
        output req_target,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_taken,
        input  req_offset,
        input  req_target,
        output req_ready
    );

endinterface

// File: rtl/bt_adder.sv
// Branch-target adder of the core: in1 is a word offset (bit 14 dropped,
// scaled by two), in2 is a byte address.
module bt_adder (
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    output logic [15:0] out
);

    assign out = {in1[15], in1[13:0], 1'b0} + in2;

endmodule

// File: rtl/pc_ras.sv
// Return-address stack: plain LIFO with refused overflow/underflow, no wrap.
module pc_ras #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [15:0]              push_data,
    output logic [15:0]              top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [15:0]   entries_q [DEPTH];
    logic [15:0]   entries_d [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] top_idx;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    // When empty the index wraps to the last slot; callers never use top then.
    assign top_idx = count_q - CW'(1);
    assign top     = entries_q[top_idx[IW-1:0]];

    always_comb begin
        entries_d = entries_q;
        count_d   = count_q;
        if (push && !full) begin
            entries_d[count_q[IW-1:0]] = push_data;
            count_d                    = count_q + CW'(1);
        end else if (pop && !empty) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the PC and the RAS, and time-shares the single
// branch-target adder across increment, branch, call and return address.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          RAS_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pc_sequencer_if.slave               req,
    input  logic                        clr_err,
    output logic [15:0]                 pc,
    output logic                        done,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic                        err_ovf,
    output logic                        err_unf
);

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    logic [15:0] pc_q, pc_d;
    logic        done_q, done_d;
    logic        err_ovf_q, err_ovf_d;
    logic        err_unf_q, err_unf_d;

    logic [15:0] adder_in1;
    logic [15:0] adder_in2;
    logic [15:0] adder_out;

    logic        ras_push;
    logic        ras_pop;
    logic [15:0] ras_top;
    logic        ras_full;
    logic        ras_empty;

    assign req.req_ready = (state_q == IDLE);
    assign pc            = pc_q;
    assign done          = done_q;
    assign err_ovf       = err_ovf_q;
    assign err_unf       = err_unf_q;

    bt_adder u_adder (
        .in1 (adder_in1),
        .in2 (adder_in2),
        .out (adder_out)
    );

    pc_ras #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (adder_out),
        .top       (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    // Adder operands depend only on state and the latched op, never on live inputs.
    always_comb begin
        adder_in1 = '0;
        adder_in2 = pc_q;
        case (state_q)
            EXEC: begin
                if (is_taken_br(req_q.op, req_q.taken)) begin
                    adder_in1 = req_q.offset;
                end else if (req_q.op == OP_JMP || req_q.op == OP_RET) begin
                    adder_in1 = '0;
                end else begin
                    adder_in1 = PC_INC_IN1;
                end
            end
            CALL2:   adder_in1 = req_q.offset;
            default: adder_in1 = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        pc_d      = pc_q;
        done_d    = 1'b0;
        err_ovf_d = clr_err ? 1'b0 : err_ovf_q;
        err_unf_d = clr_err ? 1'b0 : err_unf_q;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req.req_valid) begin
                    req_d.op     = req.req_op;
                    req_d.taken  = req.req_taken;
                    req_d.offset = req.req_offset;
                    req_d.target = req.req_target;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                state_d = IDLE;
                done_d  = 1'b1;
                case (req_q.op)
                    OP_JMP: pc_d = req_q.target;
                    OP_CALL: begin
                        // PC stays at the call address so CALL2 can add the offset to it.
                        done_d  = 1'b0;
                        state_d = CALL2;
                        if (!ras_full) begin
                            ras_push = 1'b1;
                        end else begin
                            err_ovf_d = 1'b1;
                        end
                    end
                    OP_RET: begin
                        if (!ras_empty) begin
                            pc_d    = ras_top;
                            ras_pop = 1'b1;
                        end else begin
                            err_unf_d = 1'b1;
                        end
                    end
                    default: pc_d = adder_out;
                endcase
            end
            CALL2: begin
                pc_d    = adder_out;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= '0;
            pc_q      <= RESET_PC;
            done_q    <= 1'b0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pc_q      <= pc_d;
            done_q    <= done_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller for the 16-bit multicycle RISC core. It owns the PC register and a small return-address stack (RAS). It time-shares the single existing branch-target adder instance (out = {in1[15], in1[13:0], 1'b0} + in2) across sequential increment, branch, call and return-address computation. The main control FSM issues one PC-update request per instruction through a valid/ready handshake.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
RAS_DEPTH, 4, number of return-address stack entries (power of 2, at least 2).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  PC-update request from the control FSM.
req_ready  out  1  high only in IDLE; a request is accepted on req_valid & req_ready.
req_op  in  3  0=SEQ, 1=BR, 2=JMP, 3=CALL, 4=RET; codes 5-7 behave as SEQ.
req_taken  in  1  branch condition; used only for BR.
req_offset  in  16  signed word offset for BR and CALL.
req_target  in  16  absolute target for JMP.
clr_err  in  1  synchronous clear of the sticky error flags.
pc  out  16  current PC.
done  out  1  one-cycle pulse, coincident with the first cycle the new pc is visible.
ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
err_ovf  out  1  sticky: CALL issued with the RAS full.
err_unf  out  1  sticky: RET issued with the RAS empty.

Behaviour:
- Reset (async, rst_n=0) forces: pc=RESET_PC, state IDLE, req_ready=1, done=0, ras_count=0, err_ovf=0, err_unf=0. Reset takes effect immediately, mid-operation included, and any in-flight request is discarded.
- At acceptance, latch req_op, req_taken, req_offset and req_target. Inputs are ignored outside IDLE.
- States: IDLE, EXEC, CALL2.
  - IDLE: on accept -> EXEC.
  - EXEC for SEQ, not-taken BR, and illegal ops: adder(in1=16'h0001, in2=pc); pc <= out; -> IDLE.
  - EXEC for taken BR: adder(in1=offset, in2=pc); pc <= out; -> IDLE.
  - EXEC for JMP: pc <= target; adder unused; -> IDLE.
  - EXEC for RET with ras_count>0: pc <= top entry; pop; -> IDLE.
  - EXEC for RET with the RAS empty: pc unchanged; err_unf <= 1; -> IDLE.
  - EXEC for CALL: adder(16'h0001, pc) gives the return address. If not full, push it. If full, no push, err_ovf <= 1. -> CALL2.
  - CALL2: adder(offset, pc); pc still holds the call address; pc <= out; -> IDLE.
- Latency from accept edge N:
  - pc updates at edge N+1 (CALL: N+2).
  - done is registered and is high in the cycle after the pc update; req_ready is also high that cycle.
  - Maximum throughput: one request per 2 cycles (CALL: 3).
- Arithmetic:
  - Adder results are modulo 2^16; wrap (e.g. 0xFFFE+2 -> 0x0000) is legal and silent.
  - in1 bit 14 is discarded by the adder. Offsets are therefore 15-bit signed (bit 15 = sign) scaled by 2.
- RAS:
  - LIFO with no internal wrap: a push when full is dropped and a pop when empty is refused. Contents are unaffected by either.
  - At most one push or one pop per request.
- Errors: sticky until clr_err or reset. If clr_err and a new error occur in the same cycle, the new error wins (flag = 1).
- The adder's in1/in2 multiplexer is driven from the state and the latched op only. In IDLE, drive in1=0, in2=pc, with the output unused.

Decomposition:
- Package pc_seq_pkg holds:
  - op-code constants OP_SEQ..OP_RET;
  - state encoding IDLE/EXEC/CALL2;
  - the constant PC_INC_IN1 = 16'h0001.
- Instantiate the existing adder module once; do not duplicate its arithmetic.
- Put the RAS in a sub-module pc_ras. It is parameterised by RAS_DEPTH, with push, pop, top, count, full and empty signals.

Test Plan:
1. Reset -> pc=0x0000, req_ready=1, done=0, ras_count=0. Then SEQ -> pc=0x0002, done pulses one cycle later.
2. BR at pc=0x0002:
   - taken, offset 0x0005 -> pc=0x000C;
   - then taken, offset 0xFFFE (adder in1 -> 0xFFFC) -> pc=0x0008;
   - then not-taken -> pc=0x000A.
3. JMP target 0x0100, then CALL offset 0x0010:
   - after 3 cycles pc=0x0120, ras_count=1;
   - then RET -> pc=0x0102, ras_count=0.
4. Five consecutive CALLs with offset 0x0001, starting at pc=0x0000:
   - pc after each is 0x0002, 0x0004, 0x0006, 0x0008, 0x000A;
   - err_ovf rises on the fifth, ras_count stays 4;
   - RETs then return 0x0008, 0x0006, 0x0004, 0x0002.
5. RET with ras_count=0 at pc=0x0040 -> pc stays 0x0040, err_unf=1, done pulses. Then clr_err -> err_unf=0.
6. Assert rst_n low during CALL2 after a JMP to 0x0200 -> pc immediately 0x0000, ras_count=0, req_ready=1, and no done pulse.
